// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared PIDs, token field positions and scheduler state encoding
// Purpose: constants and types common to usb_tx_scheduler and usb_ipg_timer.
// Ports: none (package).
package usb_pkg;

  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // ULPI TX CMD prefix for a PID byte
  localparam logic [7:0] ULPI_TX_CMD = 8'h40;

  // Token layout: {crc5, ep, addr, pid}
  localparam int TOK_PID_LSB  = 0;
  localparam int TOK_ADDR_LSB = 8;
  localparam int TOK_EP_LSB   = 15;
  localparam int TOK_CRC_LSB  = 19;
  localparam int TOK_W        = 24;

  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    TURN,
    SEND_HS,
    SEND_PID,
    SEND_DATA,
    WAIT_ACK
  } state_e;

  function automatic logic [7:0] pid_tx_cmd(input logic [7:0] pid);
    return ULPI_TX_CMD | {4'h0, pid[3:0]};
  endfunction

endpackage

// File: rtl/usb_ipg_timer.sv
// rtl/usb_ipg_timer.sv - down-counter for turnaround and timeout intervals
// Purpose: loads a count on start and counts down to zero; expired while zero.
// Ports: clk, rst (sync, active-high), start_i (load strobe), load_i (count - 1),
//        expired_o (count has reached zero).
module usb_ipg_timer
  import usb_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] load_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = load_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loading N-1 makes the owning state last exactly N cycles.
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/usb_tx_scheduler.sv
// rtl/usb_tx_scheduler.sv - USB device-side token/handshake/IN-data transmit scheduler
// Purpose: decodes tokens for this device, tracks data toggles for two endpoints,
//          and sequences handshake and IN data bytes to the ULPI transmitter.
// Ports: USB_CLKIN/RST clock and sync reset; token_i/token_strb_i token input;
//        rx_pid_i/rx_end_i/rx_fail_i received DATA packet; ack_strb_i host ACK;
//        dev_addr_i; ep_* endpoint flags/data; ep_sel_o/ep_rd_o endpoint access;
//        tx_data_o/tx_valid_o/tx_last_o/tx_ready_i transmit stream;
//        ep_done_o completion pulse; busy_o not-IDLE.
module usb_tx_scheduler
  import usb_pkg::*;
#(
  parameter int TURNAROUND_CYC = 8,
  parameter int TIMEOUT_CYC    = 100
) (
  input  logic             USB_CLKIN,
  input  logic             RST,
  input  logic [TOK_W-1:0] token_i,
  input  logic             token_strb_i,
  input  logic [7:0]       rx_pid_i,
  input  logic             rx_end_i,
  input  logic             rx_fail_i,
  input  logic             ack_strb_i,
  input  logic [6:0]       dev_addr_i,
  input  logic [1:0]       ep_stall_i,
  input  logic [1:0]       ep_out_full_i,
  input  logic [1:0]       ep_rdy_i,
  input  logic [1:0]       ep_zlp_i,
  output logic             ep_sel_o,
  output logic             ep_rd_o,
  input  logic [7:0]       ep_data_i,
  input  logic             ep_last_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  output logic             tx_last_o,
  input  logic             tx_ready_i,
  output logic [1:0]       ep_done_o,
  output logic             busy_o
);

  localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURNAROUND_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(TIMEOUT_CYC - 1);

  state_e     state_q, state_d;
  logic       ep_q, ep_d;
  logic       setup_q, setup_d;   // current transaction began with SETUP
  logic       hs_q, hs_d;         // after TURN: send handshake rather than DATA PID
  logic [7:0] pid_q, pid_d;
  logic [1:0] out_tog_q, out_tog_d;
  logic [1:0] in_tog_q, in_tog_d;
  logic [1:0] ep_done_q, ep_done_d;

  logic             tmr_start;
  logic [TMR_W-1:0] tmr_load;
  logic             tmr_expired;

  logic [7:0] tok_pid;
  logic [6:0] tok_addr;
  logic [3:0] tok_ep;
  logic       tok_ok;
  logic       unused_tok_crc;

  assign tok_pid        = token_i[TOK_ADDR_LSB-1:TOK_PID_LSB];
  assign tok_addr       = token_i[TOK_EP_LSB-1:TOK_ADDR_LSB];
  assign tok_ep         = token_i[TOK_CRC_LSB-1:TOK_EP_LSB];
  assign unused_tok_crc = ^token_i[TOK_W-1:TOK_CRC_LSB];

  assign tok_ok = token_strb_i && (tok_addr == dev_addr_i) && (tok_ep < 4'd2) &&
                  ((tok_pid == PID_SETUP) || (tok_pid == PID_OUT) || (tok_pid == PID_IN));

  usb_ipg_timer #(.W(TMR_W)) u_timer (
    .clk       (USB_CLKIN),
    .rst       (RST),
    .start_i   (tmr_start),
    .load_i    (tmr_load),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge USB_CLKIN) begin
    if (RST) begin
      state_q   <= IDLE;
      ep_q      <= 1'b0;
      setup_q   <= 1'b0;
      hs_q      <= 1'b0;
      pid_q     <= 8'h00;
      out_tog_q <= 2'b00;
      in_tog_q  <= 2'b00;
      ep_done_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      ep_q      <= ep_d;
      setup_q   <= setup_d;
      hs_q      <= hs_d;
      pid_q     <= pid_d;
      out_tog_q <= out_tog_d;
      in_tog_q  <= in_tog_d;
      ep_done_q <= ep_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ep_d      = ep_q;
    setup_d   = setup_q;
    hs_d      = hs_q;
    pid_d     = pid_q;
    out_tog_d = out_tog_q;
    in_tog_d  = in_tog_q;
    ep_done_d = 2'b00;
    tmr_start = 1'b0;
    tmr_load  = TURN_LOAD;
    case (state_q)
      IDLE: begin
        if (tok_ok) begin
          ep_d      = tok_ep[0];
          setup_d   = (tok_pid == PID_SETUP);
          tmr_start = 1'b1;
          if (tok_pid == PID_IN) begin
            state_d = TURN;
            hs_d    = 1'b1;
            if (ep_stall_i[tok_ep[0]]) begin
              pid_d = PID_STALL;
            end else if (!ep_rdy_i[tok_ep[0]]) begin
              pid_d = PID_NAK;
            end else begin
              hs_d  = 1'b0;
              pid_d = in_tog_q[tok_ep[0]] ? PID_DATA1 : PID_DATA0;
            end
          end else begin
            state_d  = WAIT_DATA;
            tmr_load = TMO_LOAD;
            if (tok_pid == PID_SETUP) begin
              out_tog_d[0] = 1'b0;
              in_tog_d[0]  = 1'b0;
            end
          end
        end
      end
      WAIT_DATA: begin
        if (rx_fail_i) begin
          state_d = IDLE;
        end else if (rx_end_i) begin
          state_d   = TURN;
          hs_d      = 1'b1;
          tmr_start = 1'b1;
          if (!setup_q && ep_stall_i[ep_q]) begin
            pid_d = PID_STALL;
          end else if (!setup_q && ep_out_full_i[ep_q]) begin
            pid_d = PID_NAK;
          end else begin
            pid_d = PID_ACK;
            // A repeated (wrong-toggle) packet is ACKed but not consumed.
            if (rx_pid_i == (out_tog_q[ep_q] ? PID_DATA1 : PID_DATA0)) begin
              out_tog_d[ep_q] = ~out_tog_q[ep_q];
              ep_done_d[ep_q] = 1'b1;
            end
          end
        end else if (tmr_expired) begin
          state_d = IDLE;
        end
      end
      TURN: begin
        if (tmr_expired) begin
          state_d = hs_q ? SEND_HS : SEND_PID;
        end
      end
      SEND_HS: begin
        if (tx_ready_i) begin
          state_d = IDLE;
        end
      end
      SEND_PID: begin
        if (tx_ready_i) begin
          if (ep_zlp_i[ep_q]) begin
            state_d   = WAIT_ACK;
            tmr_start = 1'b1;
            tmr_load  = TMO_LOAD;
          end else begin
            state_d = SEND_DATA;
          end
        end
      end
      SEND_DATA: begin
        if (tx_ready_i && ep_last_i) begin
          state_d   = WAIT_ACK;
          tmr_start = 1'b1;
          tmr_load  = TMO_LOAD;
        end
      end
      WAIT_ACK: begin
        if (ack_strb_i) begin
          in_tog_d[ep_q]  = ~in_tog_q[ep_q];
          ep_done_d[ep_q] = 1'b1;
          state_d         = IDLE;
        end else if (tmr_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid_o = 1'b0;
    tx_last_o  = 1'b0;
    tx_data_o  = 8'h00;
    ep_rd_o    = 1'b0;
    case (state_q)
      SEND_HS: begin
        tx_valid_o = 1'b1;
        tx_last_o  = 1'b1;
        tx_data_o  = pid_tx_cmd(pid_q);
      end
      SEND_PID: begin
        tx_valid_o = 1'b1;
        tx_last_o  = ep_zlp_i[ep_q];
        tx_data_o  = pid_tx_cmd(pid_q);
      end
      SEND_DATA: begin
        tx_valid_o = 1'b1;
        tx_last_o  = ep_last_i;
        tx_data_o  = ep_data_i;
        ep_rd_o    = tx_ready_i;
      end
      default: begin
        tx_valid_o = 1'b0;
      end
    endcase
  end

  assign busy_o    = (state_q != IDLE);
  assign ep_sel_o  = ep_q;
  assign ep_done_o = ep_done_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb/tb_usb_tx_scheduler.sv - directed self-checking bench for usb_tx_scheduler
module tb_usb_tx_scheduler;

  logic        USB_CLKIN = 1'b0;
  logic        RST = 1'b1;
  logic [23:0] token_i = '0;
  logic        token_strb_i = 1'b0;
  logic [7:0]  rx_pid_i = '0;
  logic        rx_end_i = 1'b0;
  logic        rx_fail_i = 1'b0;
  logic        ack_strb_i = 1'b0;
  logic [6:0]  dev_addr_i = 7'h05;
  logic [1:0]  ep_stall_i = '0;
  logic [1:0]  ep_out_full_i = '0;
  logic [1:0]  ep_rdy_i = '0;
  logic [1:0]  ep_zlp_i = '0;
  logic        ep_sel_o;
  logic        ep_rd_o;
  logic [7:0]  ep_data_i = '0;
  logic        ep_last_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_last_o;
  logic        tx_ready_i = 1'b0;
  logic [1:0]  ep_done_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 USB_CLKIN = ~USB_CLKIN;

  usb_tx_scheduler #(.TURNAROUND_CYC(8), .TIMEOUT_CYC(100)) dut (
    .USB_CLKIN     (USB_CLKIN),
    .RST           (RST),
    .token_i       (token_i),
    .token_strb_i  (token_strb_i),
    .rx_pid_i      (rx_pid_i),
    .rx_end_i      (rx_end_i),
    .rx_fail_i     (rx_fail_i),
    .ack_strb_i    (ack_strb_i),
    .dev_addr_i    (dev_addr_i),
    .ep_stall_i    (ep_stall_i),
    .ep_out_full_i (ep_out_full_i),
    .ep_rdy_i      (ep_rdy_i),
    .ep_zlp_i      (ep_zlp_i),
    .ep_sel_o      (ep_sel_o),
    .ep_rd_o       (ep_rd_o),
    .ep_data_i     (ep_data_i),
    .ep_last_i     (ep_last_i),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_last_o     (tx_last_o),
    .tx_ready_i    (tx_ready_i),
    .ep_done_o     (ep_done_o),
    .busy_o        (busy_o)
  );

  typedef struct {
    logic [7:0] pid;
    logic [6:0] addr;
    logic [3:0] ep;
    logic [1:0] stall;
    logic [1:0] rdy;
    logic       exp_tx;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge USB_CLKIN);
    #1;
  endtask

  task automatic send_token(input logic [7:0] pid, input logic [6:0] addr, input logic [3:0] ep);
    token_i      = {5'h00, ep, addr, pid};
    token_strb_i = 1'b1;
    tick();
    token_strb_i = 1'b0;
  endtask

  task automatic rx_packet(input logic [7:0] pid);
    rx_pid_i = pid;
    rx_end_i = 1'b1;
    tick();
    rx_end_i = 1'b0;
  endtask

  // n counts cycles since the triggering strobe was sampled
  task automatic wait_valid(output int n);
    n = 1;
    while (!tx_valid_o && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic expect_hs(input string name, input logic [7:0] exp);
    int n;
    wait_valid(n);
    chk({name, " latency"}, n, 9);
    chk({name, " byte"}, tx_data_o, exp);
    chk({name, " last"}, tx_last_o, 1'b1);
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    chk({name, " back to idle"}, busy_o, 1'b0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen_valid = 1'b0;
    logic seen_busy  = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_valid_o) seen_valid = 1'b1;
      if (busy_o) seen_busy = 1'b1;
      tick();
    end
    chk({name, " valid seen"}, seen_valid, 1'b0);
    chk({name, " busy seen"}, seen_busy, 1'b0);
  endtask

  task automatic count_to_idle(output int n, output logic seen_valid);
    n = 0;
    seen_valid = 1'b0;
    while (busy_o && n < 300) begin
      if (tx_valid_o) seen_valid = 1'b1;
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic sv;
    logic [7:0] mem [3];

    vecs[0] = '{8'h69, 7'h05, 4'd1, 2'b00, 2'b00, 1'b1, 8'h4A};
    vecs[1] = '{8'h69, 7'h05, 4'd1, 2'b10, 2'b11, 1'b1, 8'h4E};
    vecs[2] = '{8'h69, 7'h06, 4'd1, 2'b00, 2'b11, 1'b0, 8'h00};
    vecs[3] = '{8'h69, 7'h05, 4'd2, 2'b00, 2'b11, 1'b0, 8'h00};
    vecs[4] = '{8'hA5, 7'h05, 4'd0, 2'b00, 2'b11, 1'b0, 8'h00};
    vecs[5] = '{8'h69, 7'h05, 4'd0, 2'b00, 2'b00, 1'b1, 8'h4A};
    vecs[6] = '{8'h69, 7'h05, 4'd0, 2'b01, 2'b01, 1'b1, 8'h4E};
    vecs[7] = '{8'hE1, 7'h06, 4'd0, 2'b00, 2'b00, 1'b0, 8'h00};
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;

    // Reset state
    tick();
    tick();
    chk("rst tx_valid", tx_valid_o, 1'b0);
    chk("rst tx_data", tx_data_o, 8'h00);
    chk("rst tx_last", tx_last_o, 1'b0);
    chk("rst busy", busy_o, 1'b0);
    chk("rst ep_rd", ep_rd_o, 1'b0);
    chk("rst ep_done", ep_done_o, 2'b00);
    chk("rst ep_sel", ep_sel_o, 1'b0);
    RST = 1'b0;
    tick();

    // Token decode and IN handshakes
    for (int i = 0; i < 8; i++) begin
      ep_stall_i = vecs[i].stall;
      ep_rdy_i   = vecs[i].rdy;
      send_token(vecs[i].pid, vecs[i].addr, vecs[i].ep);
      if (vecs[i].exp_tx) expect_hs($sformatf("vec%0d", i), vecs[i].exp_byte);
      else expect_quiet($sformatf("vec%0d", i), 15);
    end
    ep_stall_i = '0;
    ep_rdy_i   = '0;

    // SETUP + DATA0 -> ACK and done
    send_token(8'h2D, 7'h05, 4'd0);
    chk("setup busy", busy_o, 1'b1);
    rx_packet(8'hC3);
    chk("setup done", ep_done_o, 2'b01);
    expect_hs("setup ack", 8'h42);

    // Repeated DATA0 (toggle now 1) -> ACK, no done
    send_token(8'hE1, 7'h05, 4'd0);
    rx_packet(8'hC3);
    chk("out mismatch done", ep_done_o, 2'b00);
    expect_hs("out mismatch ack", 8'h42);

    send_token(8'hE1, 7'h05, 4'd0);
    rx_packet(8'h4B);
    chk("out data1 done", ep_done_o, 2'b01);
    expect_hs("out data1 ack", 8'h42);

    ep_out_full_i = 2'b01;
    send_token(8'hE1, 7'h05, 4'd0);
    rx_packet(8'hC3);
    chk("out full done", ep_done_o, 2'b00);
    expect_hs("out full nak", 8'h4A);
    ep_out_full_i = 2'b00;

    ep_stall_i = 2'b01;
    send_token(8'hE1, 7'h05, 4'd0);
    rx_packet(8'hC3);
    expect_hs("out stall", 8'h4E);
    ep_stall_i = 2'b00;

    // Toggle to 1, then SETUP must clear it and ignore stall
    send_token(8'hE1, 7'h05, 4'd0);
    rx_packet(8'hC3);
    expect_hs("out data0 ack", 8'h42);
    ep_stall_i = 2'b01;
    send_token(8'h2D, 7'h05, 4'd0);
    rx_packet(8'hC3);
    chk("setup clears toggle done", ep_done_o, 2'b01);
    expect_hs("setup stalled ack", 8'h42);
    ep_stall_i = 2'b00;

    // IN EP1 with three data bytes
    ep_rdy_i  = 2'b10;
    ep_data_i = mem[0];
    send_token(8'h69, 7'h05, 4'd1);
    wait_valid(n);
    chk("in latency", n, 9);
    chk("in pid", tx_data_o, 8'h43);
    chk("in pid last", tx_last_o, 1'b0);
    chk("in ep_sel", ep_sel_o, 1'b1);
    tx_ready_i = 1'b1;
    #1;
    chk("in pid no pop", ep_rd_o, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      ep_data_i = mem[i];
      ep_last_i = (i == 2);
      #1;
      chk($sformatf("in byte%0d", i), tx_data_o, mem[i]);
      chk($sformatf("in last%0d", i), tx_last_o, (i == 2));
      chk($sformatf("in pop%0d", i), ep_rd_o, 1'b1);
      tick();
    end
    tx_ready_i = 1'b0;
    ep_last_i  = 1'b0;
    chk("wait_ack valid", tx_valid_o, 1'b0);
    chk("wait_ack busy", busy_o, 1'b1);

    // Token during WAIT_ACK ignored; tx_ready with no valid does nothing
    send_token(8'h69, 7'h05, 4'd1);
    tx_ready_i = 1'b1;
    #1;
    chk("idle ready no pop", ep_rd_o, 1'b0);
    tick();
    tx_ready_i = 1'b0;
    chk("token in wait_ack valid", tx_valid_o, 1'b0);
    chk("token in wait_ack busy", busy_o, 1'b1);
    ack_strb_i = 1'b1;
    tick();
    ack_strb_i = 1'b0;
    chk("in ack done", ep_done_o, 2'b10);
    chk("in ack idle", busy_o, 1'b0);

    // Zero-length IN with DATA1, then ACK timeout
    ep_zlp_i = 2'b10;
    send_token(8'h69, 7'h05, 4'd1);
    wait_valid(n);
    chk("zlp pid", tx_data_o, 8'h4B);
    chk("zlp last", tx_last_o, 1'b1);
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    chk("zlp wait_ack", busy_o, 1'b1);
    count_to_idle(n, sv);
    chk("ack timeout cycles", n, 100);
    chk("ack timeout no tx", sv, 1'b0);
    ep_zlp_i = 2'b00;

    // OUT with no data packet times out; rx_fail aborts
    send_token(8'hE1, 7'h05, 4'd0);
    count_to_idle(n, sv);
    chk("data timeout cycles", n, 100);
    chk("data timeout no tx", sv, 1'b0);
    send_token(8'hE1, 7'h05, 4'd0);
    rx_fail_i = 1'b1;
    tick();
    rx_fail_i = 1'b0;
    chk("rx_fail idle", busy_o, 1'b0);
    expect_quiet("rx_fail", 12);

    // Reset mid SEND_DATA; toggle kept at 1 by the timeout above
    ep_data_i = 8'h11;
    ep_last_i = 1'b0;
    send_token(8'h69, 7'h05, 4'd1);
    wait_valid(n);
    chk("toggle kept pid", tx_data_o, 8'h4B);
    tx_ready_i = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid rst valid", tx_valid_o, 1'b0);
    chk("mid rst busy", busy_o, 1'b0);
    chk("mid rst ep_rd", ep_rd_o, 1'b0);
    chk("mid rst data", tx_data_o, 8'h00);
    tx_ready_i = 1'b0;
    send_token(8'h69, 7'h05, 4'd1);
    wait_valid(n);
    chk("post rst pid", tx_data_o, 8'h43);
    RST = 1'b1;
    tick();
    RST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
